regf_access_ctrl: RTL and testbench

Sequencer and arbiter for the MCU's single-ported 8×16 general-purpose register array. It shares the array between two requesters:
- decode, which needs two source operands (SR1/SR2);
- writeback, which writes one destination register (DR).

The block serializes both reads onto the one array port, returns both operands with a done strobe, and arbitrates against writeback with alternating priority on ties. It sits between the instruction decode/control FSM and the register array.

---
 rtl/regf_access_ctrl.sv | 145 ++++++++++++++
 tb/tb_regf_access_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regf_access_ctrl.sv
// Read/write sequencer and arbiter for the single-ported 8x16 register array.
// Optional macro REGF_DUPREAD_SKIP_EN: duplicate-index reads skip the second array read.
module regf_access_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              RD_REQ,
    input  logic [ADDR_W-1:0] SR1,
    input  logic [ADDR_W-1:0] SR2,
    input  logic              WR_REQ,
    input  logic [ADDR_W-1:0] DR,
    input  logic [DATA_W-1:0] WR_DATA,
    input  logic [DATA_W-1:0] RF_RDATA,
    output logic [ADDR_W-1:0] RF_ADDR,
    output logic              RF_WE,
    output logic [DATA_W-1:0] RF_WDATA,
    output logic [DATA_W-1:0] SR1OUT,
    output logic [DATA_W-1:0] SR2OUT,
    output logic              RD_DONE,
    output logic              WR_ACK,
    output logic              BUSY
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_RD1  = 3'd2,
        S_RD2  = 3'd3,
        S_CAP  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic                last_wr_q;
    logic [ADDR_W-1:0]   dr_q;
    logic [ADDR_W-1:0]   sr1_q;
    logic [ADDR_W-1:0]   sr2_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   sr1out_q;
    logic [DATA_W-1:0]   sr2out_q;
    logic                wr_accept;
    logic                rd_accept;
    logic                dup_idx;

    assign dup_idx = (sr1_q == sr2_q);

    // Ties go to whichever side was not granted last, so neither starves.
    always_comb begin
        wr_accept = 1'b0;
        rd_accept = 1'b0;
        if (state_q == S_IDLE) begin
            if (WR_REQ && (!RD_REQ || !last_wr_q)) begin
                wr_accept = 1'b1;
            end else if (RD_REQ) begin
                rd_accept = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (wr_accept) begin
                    state_d = S_WR;
                end else if (rd_accept) begin
                    state_d = S_RD1;
                end
            end
            S_WR:  state_d = S_IDLE;
`ifdef REGF_DUPREAD_SKIP_EN
            S_RD1: state_d = dup_idx ? S_CAP : S_RD2;
`else
            S_RD1: state_d = S_RD2;
`endif
            S_RD2:  state_d = S_CAP;
            S_CAP:  state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            last_wr_q <= 1'b0;
            dr_q      <= '0;
            sr1_q     <= '0;
            sr2_q     <= '0;
            wdata_q   <= '0;
            sr1out_q  <= '0;
            sr2out_q  <= '0;
        end else begin
            state_q <= state_d;
            if (wr_accept) begin
                last_wr_q <= 1'b1;
                dr_q      <= DR;
                wdata_q   <= WR_DATA;
            end
            if (rd_accept) begin
                last_wr_q <= 1'b0;
                sr1_q     <= SR1;
                sr2_q     <= SR2;
            end
            // Array data lags the address by one cycle: RD2 sees SR1's word, CAP sees SR2's.
            if (state_q == S_RD2) begin
                sr1out_q <= RF_RDATA;
            end
            if (state_q == S_CAP) begin
                sr2out_q <= RF_RDATA;
`ifdef REGF_DUPREAD_SKIP_EN
                if (dup_idx) begin
                    sr1out_q <= RF_RDATA;
                end
`endif
            end
        end
    end

    always_comb begin
        RF_ADDR = '0;
        RF_WE   = 1'b0;
        WR_ACK  = 1'b0;
        RD_DONE = 1'b0;
        case (state_q)
            S_WR: begin
                RF_ADDR = dr_q;
                RF_WE   = 1'b1;
                WR_ACK  = 1'b1;
            end
            S_RD1:  RF_ADDR = sr1_q;
            S_RD2:  RF_ADDR = sr2_q;
            S_DONE: RD_DONE = 1'b1;
            default: ;
        endcase
    end

    assign BUSY     = (state_q != S_IDLE);
    assign RF_WDATA = wdata_q;
    assign SR1OUT   = sr1out_q;
    assign SR2OUT   = sr2out_q;

endmodule

// File: tb/tb_regf_access_ctrl.sv
// Directed bench for regf_access_ctrl with a one-cycle-latency register array model.
module tb_regf_access_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        RD_REQ;
    logic [2:0]  SR1;
    logic [2:0]  SR2;
    logic        WR_REQ;
    logic [2:0]  DR;
    logic [15:0] WR_DATA;
    logic [15:0] RF_RDATA;
    logic [2:0]  RF_ADDR;
    logic        RF_WE;
    logic [15:0] RF_WDATA;
    logic [15:0] SR1OUT;
    logic [15:0] SR2OUT;
    logic        RD_DONE;
    logic        WR_ACK;
    logic        BUSY;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

`ifdef REGF_DUPREAD_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    regf_access_ctrl #(.DATA_W(16), .ADDR_W(3)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .RD_REQ   (RD_REQ),
        .SR1      (SR1),
        .SR2      (SR2),
        .WR_REQ   (WR_REQ),
        .DR       (DR),
        .WR_DATA  (WR_DATA),
        .RF_RDATA (RF_RDATA),
        .RF_ADDR  (RF_ADDR),
        .RF_WE    (RF_WE),
        .RF_WDATA (RF_WDATA),
        .SR1OUT   (SR1OUT),
        .SR2OUT   (SR2OUT),
        .RD_DONE  (RD_DONE),
        .WR_ACK   (WR_ACK),
        .BUSY     (BUSY)
    );

    always #5 CLK = ~CLK;

    logic [15:0] mem [8];
    always @(posedge CLK) begin
        if (RF_WE) mem[RF_ADDR] <= RF_WDATA;
        RF_RDATA <= mem[RF_ADDR];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          wr;
        logic [2:0]  a;
        logic [2:0]  b;
        logic [15:0] d;
        logic [15:0] e1;
        logic [15:0] e2;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
    endtask

    task automatic do_write(input logic [2:0] dr, input logic [15:0] d);
        WR_REQ = 1'b1; DR = dr; WR_DATA = d;
        tick();
        WR_REQ = 1'b0; DR = ~dr; WR_DATA = ~d;
        chk("wr_we",    32'(RF_WE), 32'd1);
        chk("wr_ack",   32'(WR_ACK), 32'd1);
        chk("wr_addr",  32'(RF_ADDR), 32'(dr));
        chk("wr_wdata", 32'(RF_WDATA), 32'(d));
        tick();
        chk("wr_idle_busy", 32'(BUSY), 32'd0);
        chk("wr_idle_we",   32'(RF_WE), 32'd0);
        chk("wr_hold_wdata", 32'(RF_WDATA), 32'(d));
    endtask

    task automatic do_read(input logic [2:0] a, input logic [2:0] b,
                           input logic [15:0] e1, input logic [15:0] e2);
        bit dup;
        dup = SKIP && (a == b);
        RD_REQ = 1'b1; SR1 = a; SR2 = b;
        tick();                                   // N+1
        RD_REQ = 1'b0; SR1 = ~a; SR2 = ~b;
        chk("rd_n1_addr", 32'(RF_ADDR), 32'(a));
        chk("rd_n1_busy", 32'(BUSY), 32'd1);
        tick();                                   // N+2
        if (!dup) chk("rd_n2_addr", 32'(RF_ADDR), 32'(b));
        chk("rd_n2_done", 32'(RD_DONE), 32'd0);
        tick();                                   // N+3
        if (dup) begin
            chk("rd_n3_done", 32'(RD_DONE), 32'd1);
        end else begin
            chk("rd_n3_sr1", 32'(SR1OUT), 32'(e1));
            chk("rd_n3_done", 32'(RD_DONE), 32'd0);
            tick();                               // N+4
            chk("rd_n4_done", 32'(RD_DONE), 32'd1);
        end
        chk("rd_sr1out", 32'(SR1OUT), 32'(e1));
        chk("rd_sr2out", 32'(SR2OUT), 32'(e2));
        tick();
        chk("rd_after_done", 32'(RD_DONE), 32'd0);
        chk("rd_after_busy", 32'(BUSY), 32'd0);
    endtask

    initial begin
        int unsigned k;
        int unsigned got_k;
        int unsigned ngrant;
        int unsigned overlap;
        bit          order [4];
        bit          exp_order [4];

        RESET = 1'b0; RD_REQ = 1'b0; WR_REQ = 1'b0;
        SR1 = '0; SR2 = '0; DR = '0; WR_DATA = '0;

        vecs[0]  = '{1'b1, 3'd3, 3'd0, 16'h1234, 16'h0000, 16'h0000};
        vecs[1]  = '{1'b1, 3'd1, 3'd0, 16'hAAAA, 16'h0000, 16'h0000};
        vecs[2]  = '{1'b1, 3'd2, 3'd0, 16'h5555, 16'h0000, 16'h0000};
        vecs[3]  = '{1'b0, 3'd1, 3'd2, 16'h0000, 16'hAAAA, 16'h5555};
        vecs[4]  = '{1'b1, 3'd0, 3'd0, 16'h0001, 16'h0000, 16'h0000};
        vecs[5]  = '{1'b1, 3'd7, 3'd0, 16'hFFFF, 16'h0000, 16'h0000};
        vecs[6]  = '{1'b0, 3'd0, 3'd7, 16'h0000, 16'h0001, 16'hFFFF};
        vecs[7]  = '{1'b0, 3'd7, 3'd0, 16'h0000, 16'hFFFF, 16'h0001};
        vecs[8]  = '{1'b1, 3'd5, 3'd0, 16'h0F0F, 16'h0000, 16'h0000};
        vecs[9]  = '{1'b0, 3'd5, 3'd5, 16'h0000, 16'h0F0F, 16'h0F0F};
        vecs[10] = '{1'b1, 3'd3, 3'd0, 16'hC3A5, 16'h0000, 16'h0000};
        vecs[11] = '{1'b0, 3'd3, 3'd1, 16'h0000, 16'hC3A5, 16'hAAAA};

        // Reset state
        do_reset();
        chk("rst_busy",  32'(BUSY), 32'd0);
        chk("rst_we",    32'(RF_WE), 32'd0);
        chk("rst_addr",  32'(RF_ADDR), 32'd0);
        chk("rst_wdata", 32'(RF_WDATA), 32'd0);
        chk("rst_sr1",   32'(SR1OUT), 32'd0);
        chk("rst_sr2",   32'(SR2OUT), 32'd0);
        chk("rst_done",  32'(RD_DONE), 32'd0);
        chk("rst_ack",   32'(WR_ACK), 32'd0);

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) do_write(vecs[i].a, vecs[i].d);
            else            do_read(vecs[i].a, vecs[i].b, vecs[i].e1, vecs[i].e2);
        end

        // Tie from reset: write wins, then read returns the new value
        do_reset();
        chk("tie_rst_wdata", 32'(RF_WDATA), 32'd0);
        WR_REQ = 1'b1; DR = 3'd3; WR_DATA = 16'hBEEF;
        RD_REQ = 1'b1; SR1 = 3'd3; SR2 = 3'd3;
        got_k = 0;
        for (k = 1; k <= 12; k++) begin
            tick();
            if (k == 1) begin
                chk("tie_wr_ack", 32'(WR_ACK), 32'd1);
                chk("tie_wr_addr", 32'(RF_ADDR), 32'd3);
                WR_REQ = 1'b0;
            end
            if (k == 2) chk("tie_idle_n2", 32'(BUSY), 32'd0);
            if (k == 3) RD_REQ = 1'b0;
            if (RD_DONE) begin
                got_k = k;
                break;
            end
        end
        chk("tie_rd_done_cycle", 32'(got_k), SKIP ? 32'd5 : 32'd6);
        chk("tie_sr1", 32'(SR1OUT), 32'hBEEF);
        chk("tie_sr2", 32'(SR2OUT), 32'hBEEF);
        tick();

        // Both held: grants alternate W,R,W,R with no overlapping strobes
        WR_REQ = 1'b1; DR = 3'd6; WR_DATA = 16'h6666;
        RD_REQ = 1'b1; SR1 = 3'd6; SR2 = 3'd6;
        ngrant = 0; overlap = 0;
        for (int c = 0; c < 40 && ngrant < 4; c++) begin
            tick();
            if (WR_ACK && RD_DONE) overlap++;
            if (WR_ACK)  begin order[ngrant] = 1'b0; ngrant++; end
            else if (RD_DONE) begin order[ngrant] = 1'b1; ngrant++; end
        end
        WR_REQ = 1'b0; RD_REQ = 1'b0;
        exp_order[0] = 1'b0; exp_order[1] = 1'b1;
        exp_order[2] = 1'b0; exp_order[3] = 1'b1;
        chk("alt_grants", 32'(ngrant), 32'd4);
        chk("alt_overlap", 32'(overlap), 32'd0);
        for (int g = 0; g < 4; g++) begin
            if (g < int'(ngrant)) chk($sformatf("alt_order%0d", g), 32'(order[g]), 32'(exp_order[g]));
        end
        chk("alt_read_val", 32'(SR2OUT), 32'h6666);
        for (int c = 0; c < 6; c++) tick();
        chk("alt_drain_busy", 32'(BUSY), 32'd0);

        // Reset during RD2 aborts the read
        RD_REQ = 1'b1; SR1 = 3'd1; SR2 = 3'd2;
        tick();                                   // RD1
        RD_REQ = 1'b0;
        tick();                                   // RD2
        chk("abort_in_rd2_addr", 32'(RF_ADDR), 32'd2);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk("abort_busy", 32'(BUSY), 32'd0);
        chk("abort_sr1",  32'(SR1OUT), 32'd0);
        chk("abort_sr2",  32'(SR2OUT), 32'd0);
        chk("abort_done", 32'(RD_DONE), 32'd0);
        got_k = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (RD_DONE || WR_ACK) got_k++;
        end
        chk("abort_no_strobe", 32'(got_k), 32'd0);

        do_read(3'd1, 3'd2, 16'hAAAA, 16'h5555);
        do_read(3'd5, 3'd5, 16'h0F0F, 16'h0F0F);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
